// File: rtl/hub75_pkg.sv
// hub75_pkg: shared state encoding and channel layout for the HUB-75 scan-out.
// Rev 1.0
`default_nettype none

package hub75_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    BLANK   = 3'd2,
    LATCH   = 3'd3,
    DISPLAY = 3'd4,
    DONE    = 3'd5
  } hub75_state_t;

  localparam int R1 = 0;
  localparam int G1 = 1;
  localparam int B1 = 2;
  localparam int R2 = 3;
  localparam int G2 = 4;
  localparam int B2 = 5;

  localparam int CHANNELS = 6;

endpackage

`default_nettype wire

// File: rtl/hub75_scanout.sv
// hub75_scanout: shifts one buffered line onto a HUB-75 panel once per bit-plane
// with binary-weighted display time. Rev 1.0
`default_nettype none

module hub75_scanout
  import hub75_pkg::*;
#(
  parameter int address_width     = 6,
  parameter int color_depth       = 4,
  parameter int row_address_width = 4,
  parameter int display_base      = 16
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                line_valid,
  input  logic [row_address_width-1:0]        line_row,
  output logic                                line_start,
  output logic                                line_done,
  output logic                                busy,
  output logic [address_width-1:0]            read_address,
  input  logic [CHANNELS*color_depth-1:0]     read_data,
  output logic                                hub_r1,
  output logic                                hub_g1,
  output logic                                hub_b1,
  output logic                                hub_r2,
  output logic                                hub_g2,
  output logic                                hub_b2,
  output logic                                hub_clk,
  output logic                                hub_lat,
  output logic                                hub_oe_n,
  output logic [row_address_width-1:0]        hub_row
);

  localparam int plane_width = (color_depth > 1) ? $clog2(color_depth) : 1;
  localparam logic [address_width-1:0] last_column = '1;
  localparam logic [plane_width-1:0]   last_plane  = plane_width'(color_depth - 1);

  hub75_state_t                 state, state_next;
  logic                         phase, phase_next;
  logic [address_width-1:0]     column, column_next;
  logic [plane_width-1:0]       plane, plane_next;
  logic [31:0]                  display_count, display_count_next;
  logic [row_address_width-1:0] row, row_next;
  logic [31:0]                  display_length;
  logic [color_depth-1:0]       channel_field [CHANNELS];
  logic [CHANNELS-1:0]          plane_bits;

  assign display_length = 32'(display_base) << plane;
  assign read_address   = column;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_channel
    assign channel_field[k] = read_data[k*color_depth +: color_depth];
    assign plane_bits[k]    = channel_field[k][plane];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      phase         <= 1'b0;
      column        <= '0;
      plane         <= '0;
      display_count <= '0;
      row           <= '0;
    end else begin
      state         <= state_next;
      phase         <= phase_next;
      column        <= column_next;
      plane         <= plane_next;
      display_count <= display_count_next;
      row           <= row_next;
    end
  end

  always_comb begin
    state_next         = state;
    phase_next         = phase;
    column_next        = column;
    plane_next         = plane;
    display_count_next = display_count;
    row_next           = row;
    unique case (state)
      IDLE: begin
        if (line_valid) begin
          row_next    = line_row;
          plane_next  = '0;
          column_next = '0;
          phase_next  = 1'b0;
          state_next  = SHIFT;
        end
      end
      SHIFT: begin
        phase_next = ~phase;
        if (phase) begin
          column_next = column + 1'b1;
          if (column == last_column) state_next = BLANK;
        end
      end
      BLANK: state_next = LATCH;
      LATCH: begin
        display_count_next = '0;
        state_next         = DISPLAY;
      end
      DISPLAY: begin
        display_count_next = display_count + 32'd1;
        if (display_count == display_length - 32'd1) begin
          if (plane == last_plane) begin
            state_next = DONE;
          end else begin
            plane_next  = plane + 1'b1;
            column_next = '0;
            phase_next  = 1'b0;
            state_next  = SHIFT;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pins trail the state by one cycle so each column's data sits one cycle
  // before its hub_clk rising edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      line_start <= 1'b0;
      line_done  <= 1'b0;
      busy       <= 1'b0;
      hub_clk    <= 1'b0;
      hub_lat    <= 1'b0;
      hub_oe_n   <= 1'b1;
      hub_row    <= '0;
      hub_r1     <= 1'b0;
      hub_g1     <= 1'b0;
      hub_b1     <= 1'b0;
      hub_r2     <= 1'b0;
      hub_g2     <= 1'b0;
      hub_b2     <= 1'b0;
    end else begin
      line_start <= (state == IDLE) && line_valid;
      line_done  <= (state == DONE);
      busy       <= (state != IDLE);
      hub_clk    <= (state == SHIFT) && phase;
      hub_lat    <= (state == LATCH);
      hub_oe_n   <= (state != DISPLAY);
      if (state == BLANK) hub_row <= row;
      if ((state == SHIFT) && !phase) begin
        hub_r1 <= plane_bits[R1];
        hub_g1 <= plane_bits[G1];
        hub_b1 <= plane_bits[B1];
        hub_r2 <= plane_bits[R2];
        hub_g2 <= plane_bits[G2];
        hub_b2 <= plane_bits[B2];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hub75_scanout.sv
// tb_hub75_scanout: directed self-checking bench for hub75_scanout. Rev 1.0
`default_nettype none

module tb_hub75_scanout;

  logic        clock = 1'b0;
  logic        reset;
  logic        line_valid;
  logic [3:0]  line_row;
  logic        line_start, line_done, busy;
  logic [1:0]  read_address;
  logic [11:0] read_data;
  logic        hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2;
  logic        hub_clk, hub_lat, hub_oe_n;
  logic [3:0]  hub_row;
  logic [11:0] line_mem [4];
  logic [5:0]  pins;

  logic        line_valid_l;
  logic        line_start_l, line_done_l, busy_l;
  logic [1:0]  read_address_l;
  logic [47:0] read_data_l;
  logic        hub_r1_l, hub_g1_l, hub_b1_l, hub_r2_l, hub_g2_l, hub_b2_l;
  logic        hub_clk_l, hub_lat_l, hub_oe_n_l;
  logic [3:0]  hub_row_l;

  int n_compared = 0;
  int n_mismatched = 0;

  logic [5:0] edge_pins [$];
  logic [3:0] lat_rows [$];
  int         disp_runs [$];
  int         start_cycle, done_cycle;
  logic       busy_at_start, busy_at_done;
  int         invariant_errors = 0;
  int         lat_order_errors = 0;
  int         setup_errors = 0;

  always #5 clock = ~clock;

  assign read_data   = line_mem[read_address];
  assign read_data_l = '0;
  assign pins        = {hub_b2, hub_g2, hub_r2, hub_b1, hub_g1, hub_r1};

  hub75_scanout #(
    .address_width(2), .color_depth(2), .row_address_width(4), .display_base(3)
  ) u_dut (
    .clock(clock), .reset(reset), .line_valid(line_valid), .line_row(line_row),
    .line_start(line_start), .line_done(line_done), .busy(busy),
    .read_address(read_address), .read_data(read_data),
    .hub_r1(hub_r1), .hub_g1(hub_g1), .hub_b1(hub_b1),
    .hub_r2(hub_r2), .hub_g2(hub_g2), .hub_b2(hub_b2),
    .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe_n(hub_oe_n), .hub_row(hub_row)
  );

  hub75_scanout #(
    .address_width(2), .color_depth(8), .row_address_width(4), .display_base(1)
  ) u_long (
    .clock(clock), .reset(reset), .line_valid(line_valid_l), .line_row(4'd9),
    .line_start(line_start_l), .line_done(line_done_l), .busy(busy_l),
    .read_address(read_address_l), .read_data(read_data_l),
    .hub_r1(hub_r1_l), .hub_g1(hub_g1_l), .hub_b1(hub_b1_l),
    .hub_r2(hub_r2_l), .hub_g2(hub_g2_l), .hub_b2(hub_b2_l),
    .hub_clk(hub_clk_l), .hub_lat(hub_lat_l), .hub_oe_n(hub_oe_n_l), .hub_row(hub_row_l)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] edge_at(input int i);
    if (i < edge_pins.size()) return edge_pins[i];
    return 6'bxxxxxx;
  endfunction

  // Pins {b2,g2,r2,b1,g1,r1} hold bit `plane` of each 2-bit channel field.
  function automatic logic [5:0] expected_pins(input logic [11:0] word, input int plane);
    logic [5:0] p;
    for (int k = 0; k < 6; k++) p[k] = word[k*2 + plane];
    return p;
  endfunction

  task automatic capture_line(input bit drop_valid, input int budget);
    logic       prev_clk;
    logic [5:0] prev_pins;
    int         run;
    int         edges_since_lat;
    bit         done_seen;
    edge_pins.delete();
    lat_rows.delete();
    disp_runs.delete();
    start_cycle = -1;
    done_cycle = -1;
    busy_at_start = 1'bx;
    busy_at_done = 1'bx;
    prev_clk = hub_clk;
    prev_pins = pins;
    run = 0;
    edges_since_lat = 0;
    done_seen = 1'b0;
    for (int c = 0; c < budget && !done_seen; c++) begin
      @(negedge clock);
      if (line_start) begin
        start_cycle = c;
        busy_at_start = busy;
        if (drop_valid) line_valid = 1'b0;
      end
      if (!hub_oe_n && (hub_clk || hub_lat)) invariant_errors++;
      if (hub_clk && !prev_clk) begin
        edge_pins.push_back(pins);
        edges_since_lat++;
        if (pins !== prev_pins) setup_errors++;
      end
      if (hub_lat) begin
        lat_rows.push_back(hub_row);
        if (edges_since_lat != 4 || hub_clk) lat_order_errors++;
        edges_since_lat = 0;
      end
      if (!hub_oe_n) run++;
      else if (run != 0) begin
        disp_runs.push_back(run);
        run = 0;
      end
      if (line_done) begin
        done_cycle = c;
        busy_at_done = busy;
        done_seen = 1'b1;
      end
      prev_clk = hub_clk;
      prev_pins = pins;
    end
    if (!done_seen) check_value("line_done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [7:0] exp_r1;
    int         seen;
    int         run;
    int         runs_l [$];
    int         start_l, done_l;
    bit         done_seen;

    reset = 1'b0;
    line_valid = 1'b0;
    line_valid_l = 1'b0;
    line_row = 4'd0;
    for (int i = 0; i < 4; i++) line_mem[i] = 12'h000;

    // Reset state
    repeat (3) @(negedge clock);
    check_value("reset_oe_n", 32'(hub_oe_n), 32'd1);
    check_value("reset_outputs",
                32'({line_start, line_done, busy, read_address, pins, hub_clk, hub_lat, hub_row}),
                32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Single line: r1 = column index, row 5
    for (int i = 0; i < 4; i++) line_mem[i] = 12'(i);
    line_row = 4'd5;
    line_valid = 1'b1;
    capture_line(1'b1, 200);
    check_value("single_line_cycles", 32'(done_cycle - start_cycle + 1), 32'd31);
    check_value("single_edges", 32'(edge_pins.size()), 32'd8);
    exp_r1 = 8'b1100_1010;
    for (int i = 0; i < 8; i++)
      check_value($sformatf("single_r1_edge%0d", i), 32'(edge_at(i)), 32'(exp_r1[i]));
    check_value("single_lat_count", 32'(lat_rows.size()), 32'd2);
    for (int i = 0; i < lat_rows.size(); i++)
      check_value($sformatf("single_row%0d", i), 32'(lat_rows[i]), 32'd5);
    check_value("single_disp_count", 32'(disp_runs.size()), 32'd2);
    if (disp_runs.size() == 2) begin
      check_value("single_disp0", 32'(disp_runs[0]), 32'd3);
      check_value("single_disp1", 32'(disp_runs[1]), 32'd6);
    end
    check_value("busy_at_start", 32'(busy_at_start), 32'd0);
    check_value("busy_at_done", 32'(busy_at_done), 32'd1);
    @(negedge clock);
    check_value("busy_after_done", 32'(busy), 32'd0);
    check_value("no_restart_after_drop", 32'(line_start), 32'd0);

    // Channel mapping: 0xA5C in every column
    for (int i = 0; i < 4; i++) line_mem[i] = 12'hA5C;
    line_row = 4'd3;
    line_valid = 1'b1;
    capture_line(1'b1, 200);
    check_value("map_plane0_col0", 32'(edge_at(0)), 32'(6'b001110));
    check_value("map_plane0_col3", 32'(edge_at(3)), 32'(6'b001110));
    check_value("map_plane1_col0", 32'(edge_at(4)), 32'(6'b110010));
    check_value("map_plane1_col3", 32'(edge_at(7)), 32'(6'b110010));

    // Back-to-back lines with line_valid held high
    line_row = 4'd7;
    line_valid = 1'b1;
    capture_line(1'b0, 200);
    check_value("b2b_first_cycles", 32'(done_cycle - start_cycle + 1), 32'd31);
    @(negedge clock);
    check_value("b2b_gap", 32'(line_start), 32'd1);
    line_valid = 1'b0;
    capture_line(1'b0, 200);
    check_value("b2b_second_edges", 32'(edge_pins.size()), 32'd8);
    check_value("b2b_second_runs", 32'(disp_runs.size()), 32'd2);
    @(negedge clock);
    check_value("b2b_stop", 32'(line_start), 32'd0);

    // Random lines: data per edge and blanking invariants
    for (int s = 0; s < 100; s++) begin
      for (int i = 0; i < 4; i++) line_mem[i] = 12'($urandom);
      line_row = 4'($urandom_range(0, 15));
      line_valid = 1'b1;
      capture_line(1'b1, 200);
      for (int i = 0; i < 8; i++)
        check_value($sformatf("rand%0d_edge%0d", s, i), 32'(edge_at(i)),
                    32'(expected_pins(line_mem[i % 4], i / 4)));
      if (lat_rows.size() > 0)
        check_value($sformatf("rand%0d_row", s), 32'(lat_rows[0]), 32'(line_row));
      else
        check_value($sformatf("rand%0d_lat", s), 32'd0, 32'd1);
    end
    check_value("blank_invariant", 32'(invariant_errors), 32'd0);
    check_value("lat_not_in_shift", 32'(lat_order_errors), 32'd0);
    check_value("data_setup", 32'(setup_errors), 32'd0);

    // Async reset mid-DISPLAY
    line_row = 4'd2;
    line_valid = 1'b1;
    seen = 0;
    for (int c = 0; c < 60 && seen == 0; c++) begin
      @(negedge clock);
      if (line_start) line_valid = 1'b0;
      if (!hub_oe_n) seen = 1;
    end
    check_value("reached_display", 32'(seen), 32'd1);
    #1 reset = 1'b0;
    #1;
    check_value("abort_oe_n", 32'(hub_oe_n), 32'd1);
    check_value("abort_busy", 32'(busy), 32'd0);
    check_value("abort_addr", 32'(read_address), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (line_done || line_start) seen++;
    end
    check_value("abort_no_done", 32'(seen), 32'd0);

    // Long plane: color_depth 8, display_base 1
    line_valid_l = 1'b1;
    run = 0;
    start_l = -1;
    done_l = -1;
    done_seen = 1'b0;
    for (int c = 0; c < 600 && !done_seen; c++) begin
      @(negedge clock);
      if (line_start_l) begin
        line_valid_l = 1'b0;
        start_l = c;
      end
      if (!hub_oe_n_l) run++;
      else if (run != 0) begin
        runs_l.push_back(run);
        run = 0;
      end
      if (line_done_l) begin
        done_l = c;
        done_seen = 1'b1;
      end
    end
    check_value("long_done_seen", 32'(done_seen), 32'd1);
    check_value("long_runs", 32'(runs_l.size()), 32'd8);
    if (runs_l.size() == 8) begin
      check_value("long_plane0", 32'(runs_l[0]), 32'd1);
      check_value("long_plane7", 32'(runs_l[7]), 32'd128);
    end
    check_value("long_line_cycles", 32'(done_l - start_l + 1), 32'd337);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

`default_nettype wire
